// File: rtl/puf_pkg.sv
// ---------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the PUF response UART reporter: the controller state
// encoding and the fixed byte values that appear on the serial line.
// ---------------------------------------------------------------------------
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_SEND_HDR  = 3'd2,
        ST_SEND_CHAL = 3'd3,
        ST_SEND_RESP = 3'd4,
        ST_ACK       = 3'd5,
        ST_WAIT_LOW  = 3'd6
    } state_t;

    // Frame header for a normal evaluation and for a timed-out evaluation.
    localparam logic [7:0] HDR_OK       = 8'hA5;
    localparam logic [7:0] HDR_ERR      = 8'h5A;
    // Response byte substituted when the PUF never reports done.
    localparam logic [7:0] RESP_TIMEOUT = 8'hEE;

endpackage

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 serialiser: start bit (0), 8 data bits LSB first, stop bit (1), each
// held for CLKS_PER_BIT clocks.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (line returns to idle high)
//   start  : load data and begin a byte; accepted whenever busy is low
//   data   : byte to send
//   busy   : byte in flight; drops during the last clock of the stop bit so a
//            following byte can start with no idle gap
//   tx     : serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             active;
    logic [CNT_W-1:0] clk_cnt;
    logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]       shift;
    logic             tx_reg;
    logic             last_cycle;

    assign last_cycle = active && (bit_idx == 4'd9) && (clk_cnt == CNT_LAST);
    assign busy       = active && !last_cycle;
    assign tx         = tx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= 4'd0;
            shift   <= 8'h00;
            tx_reg  <= 1'b1;
        end else if (start && !busy) begin
            active  <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= 4'd0;
            shift   <= data;
            tx_reg  <= 1'b0;
        end else if (active) begin
            if (clk_cnt == CNT_LAST) begin
                clk_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active  <= 1'b0;
                    bit_idx <= 4'd0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    // Leaving bit k: next is data bit k (k<8) or the stop bit.
                    tx_reg  <= (bit_idx == 4'd8) ? 1'b1 : shift[bit_idx[2:0]];
                end
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/puf_response_uart.sv
// ---------------------------------------------------------------------------
// puf_response_uart
// Arms a PUF, waits (with timeout) for its evaluation, then reports a 3-byte
// frame {header, challenge, response} over UART and strobes computer_ack to
// reset the PUF before the next evaluation.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   run          : level request; each IDLE pass with run high starts a frame
//   challenge    : challenge applied to the PUF (asynchronous, synchronised)
//   response     : PUF response bits (asynchronous, synchronised)
//   done         : PUF evaluation complete (asynchronous, synchronised)
//   puf_enable   : high while armed (ARM state)
//   computer_ack : PUF reset/acknowledge strobe (ACK and WAIT_LOW)
//   tx           : UART line, idle high
//   busy         : high whenever the controller is not idle
//   sample_count : completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module puf_response_uart
    import puf_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int ACK_CYCLES   = 4,
    parameter int TIMEOUT      = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] challenge,
    input  logic [7:0] response,
    input  logic       done,
    output logic       puf_enable,
    output logic       computer_ack,
    output logic       tx,
    output logic       busy,
    output logic [7:0] sample_count
);

    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);

    state_t state, state_next;

    // Two-flop synchronisers for the PUF-side signals.
    logic       done_meta, done_sync;
    logic [7:0] chal_meta, chal_sync;
    logic [7:0] resp_meta, resp_sync;

    logic [TO_W-1:0]  to_cnt;
    logic [ACK_W-1:0] ack_cnt;
    logic [7:0]       chal_reg;
    logic [7:0]       resp_reg;
    logic             err_reg;    // current frame was produced by timeout
    logic [7:0]       count_reg;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    logic arm_done, arm_timeout;
    assign arm_done    = done_sync;
    assign arm_timeout = !done_sync && (to_cnt == TO_LAST);

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start),
        .data  (tx_data),
        .busy  (tx_busy),
        .tx    (tx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            done_meta <= 1'b0;
            done_sync <= 1'b0;
            chal_meta <= 8'h00;
            chal_sync <= 8'h00;
            resp_meta <= 8'h00;
            resp_sync <= 8'h00;
            to_cnt    <= '0;
            ack_cnt   <= '0;
            chal_reg  <= 8'h00;
            resp_reg  <= 8'h00;
            err_reg   <= 1'b0;
            count_reg <= 8'h00;
        end else begin
            state     <= state_next;
            done_meta <= done;
            done_sync <= done_meta;
            chal_meta <= challenge;
            chal_sync <= chal_meta;
            resp_meta <= response;
            resp_sync <= resp_meta;

            case (state)
                ST_IDLE: begin
                    to_cnt  <= '0;
                    ack_cnt <= '0;
                end
                ST_ARM: begin
                    if (arm_done) begin
                        chal_reg <= chal_sync;
                        resp_reg <= resp_sync;
                        err_reg  <= 1'b0;
                    end else if (arm_timeout) begin
                        chal_reg <= chal_sync;
                        resp_reg <= RESP_TIMEOUT;
                        err_reg  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_SEND_RESP: begin
                    if (!tx_busy) begin
                        count_reg <= count_reg + 8'd1;
                        ack_cnt   <= '0;
                    end
                end
                ST_ACK: begin
                    ack_cnt <= ack_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Each byte is launched on the same edge that enters its SEND state, so
    // the serialiser is already busy on the first cycle of that state.
    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_ARM;
            end
            ST_ARM: begin
                if (arm_done) begin
                    tx_start   = 1'b1;
                    tx_data    = HDR_OK;
                    state_next = ST_SEND_HDR;
                end else if (arm_timeout) begin
                    tx_start   = 1'b1;
                    tx_data    = HDR_ERR;
                    state_next = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_data    = chal_reg;
                    state_next = ST_SEND_CHAL;
                end
            end
            ST_SEND_CHAL: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    tx_data    = resp_reg;
                    state_next = ST_SEND_RESP;
                end
            end
            ST_SEND_RESP: begin
                if (!tx_busy) state_next = ST_ACK;
            end
            ST_ACK: begin
                // A timed-out PUF never raised done, so there is nothing to wait for.
                if (ack_cnt == ACK_LAST) state_next = err_reg ? ST_IDLE : ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!done_sync) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign puf_enable   = (state == ST_ARM);
    assign computer_ack = (state == ST_ACK) || (state == ST_WAIT_LOW);
    assign busy         = (state != ST_IDLE);
    assign sample_count = count_reg;

endmodule

// File: tb/tb_puf_response_uart.sv
module tb_puf_response_uart;

    localparam int CPB  = 4;
    localparam int ACKC = 4;
    localparam int TO   = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] challenge = 8'h00;
    logic [7:0] response = 8'h00;
    logic       done_man = 1'b0;
    logic       done_auto = 1'b0;
    logic       auto_mode = 1'b0;
    logic       done;
    logic       puf_enable, computer_ack, tx, busy;
    logic [7:0] sample_count;
    logic [3:0] pe_hist = 4'h0;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       rx_stop_q[$];

    assign done = auto_mode ? done_auto : done_man;

    puf_response_uart #(
        .CLKS_PER_BIT (CPB),
        .ACK_CYCLES   (ACKC),
        .TIMEOUT      (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .challenge    (challenge),
        .response     (response),
        .done         (done),
        .puf_enable   (puf_enable),
        .computer_ack (computer_ack),
        .tx           (tx),
        .busy         (busy),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    // Behavioural PUF for back-to-back runs: done follows puf_enable a few cycles late.
    always @(posedge clk) begin
        pe_hist   <= {pe_hist[2:0], puf_enable};
        done_auto <= pe_hist[2];
    end

    // UART receiver: samples each bit in its middle on falling clock edges.
    initial begin
        logic [7:0] b;
        logic       s;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                s = tx;
                rx_q.push_back(b);
                rx_stop_q.push_back(s);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_pe_high(input int budget, output bit ok);
        int k = 0;
        @(negedge clk);
        while (puf_enable !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (puf_enable === 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b need 1", tx); end
        n_cmp++; if (puf_enable !== 1'b0) begin n_err++; $display("FAIL reset_pe got %b need 0", puf_enable); end
        n_cmp++; if (computer_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b need 0", computer_ack); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b need 0", busy); end
        n_cmp++; if (sample_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d need 0", sample_count); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin n_err++; $display("FAIL reset_release got busy=%b tx=%b need 0/1", busy, tx); end
        $display("reset: outputs checked");
    endtask

    task automatic test_normal;
        bit ok;
        int k;
        logic [7:0] e, g;
        logic s;
        challenge = 8'h3C; response = 8'h00; done_man = 1'b0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        run = 1'b1;
        wait_pe_high(10, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL normal_arm got puf_enable=%b need 1", puf_enable); end
        run = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (puf_enable !== 1'b1) begin n_err++; $display("FAIL normal_armed got puf_enable=%b need 1", puf_enable); end
        response = 8'h96; done_man = 1'b1;
        exp_q.push_back(8'h96);
        wait_rx(3, 300, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL normal_rx_wait got %0d bytes need 3", rx_q.size()); end
        while (ok && rx_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); s = rx_stop_q.pop_front();
            $display("normal: byte got %02h expected %02h stop %b", g, e, s);
            n_cmp++; if (g !== e || s !== 1'b1) begin n_err++; $display("FAIL normal_byte got %02h/stop %b need %02h/stop 1", g, s, e); end
        end
        k = 0;
        while (computer_ack !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++; if (computer_ack !== 1'b1) begin n_err++; $display("FAIL normal_ack_rise got %b need 1", computer_ack); end
        n_cmp++; if (puf_enable !== 1'b0) begin n_err++; $display("FAIL normal_pe_drop got %b need 0", puf_enable); end
        repeat (10) @(negedge clk);
        n_cmp++; if (computer_ack !== 1'b1) begin n_err++; $display("FAIL normal_ack_hold got %b need 1 while done high", computer_ack); end
        done_man = 1'b0;
        k = 0;
        while (computer_ack === 1'b1 && k < 10) begin @(negedge clk); k++; end
        n_cmp++; if (computer_ack !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL normal_ack_release got ack=%b busy=%b need 0/0", computer_ack, busy); end
        n_cmp++; if (sample_count !== 8'd1) begin n_err++; $display("FAIL normal_count got %0d need 1", sample_count); end
    endtask

    task automatic test_timeout;
        bit ok;
        int k;
        logic [7:0] e, g;
        logic s;
        challenge = 8'h71; done_man = 1'b0;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h71);
        exp_q.push_back(8'hEE);
        run = 1'b1;
        wait_pe_high(10, ok);
        run = 1'b0;
        k = 0;
        while (puf_enable === 1'b1 && k < 300) begin @(negedge clk); k++; end
        $display("timeout: puf_enable high %0d cycles", k);
        n_cmp++; if (!ok || k < TO || k > TO + 1) begin n_err++; $display("FAIL timeout_pe_len got %0d need %0d", k, TO); end
        wait_rx(3, 300, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL timeout_rx_wait got %0d bytes need 3", rx_q.size()); end
        while (ok && rx_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); s = rx_stop_q.pop_front();
            $display("timeout: byte got %02h expected %02h stop %b", g, e, s);
            n_cmp++; if (g !== e || s !== 1'b1) begin n_err++; $display("FAIL timeout_byte got %02h/stop %b need %02h/stop 1", g, s, e); end
        end
        k = 0;
        while (computer_ack !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (computer_ack === 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++; if (k !== ACKC) begin n_err++; $display("FAIL timeout_ack_len got %0d need %0d", k, ACKC); end
        n_cmp++; if (sample_count !== 8'd2) begin n_err++; $display("FAIL timeout_count got %0d need 2", sample_count); end
    endtask

    task automatic test_run_drop;
        bit ok;
        int k, viol;
        logic [7:0] e, g;
        logic s;
        challenge = 8'h2B; response = 8'hD4; done_man = 1'b0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h2B);
        exp_q.push_back(8'hD4);
        run = 1'b1;
        wait_pe_high(10, ok);
        repeat (5) @(negedge clk);
        done_man = 1'b1;
        wait_rx(1, 100, ok);
        repeat (10) @(negedge clk);
        run = 1'b0;
        done_man = 1'b0;
        wait_rx(3, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rundrop_rx_wait got %0d bytes need 3", rx_q.size()); end
        while (ok && rx_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); s = rx_stop_q.pop_front();
            $display("rundrop: byte got %02h expected %02h stop %b", g, e, s);
            n_cmp++; if (g !== e || s !== 1'b1) begin n_err++; $display("FAIL rundrop_byte got %02h/stop %b need %02h/stop 1", g, s, e); end
        end
        k = 0;
        while (busy !== 1'b0 && k < 50) begin @(negedge clk); k++; end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rundrop_idle got busy=%b need 0", busy); end
        viol = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || puf_enable !== 1'b0) viol++;
        end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL rundrop_stay_idle got %0d active cycles need 0", viol); end
        n_cmp++; if (sample_count !== 8'd3) begin n_err++; $display("FAIL rundrop_count got %0d need 3", sample_count); end
    endtask

    task automatic test_done_idle;
        int viol = 0;
        run = 1'b0;
        done_man = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 5) done_man = 1'b0;
            if (busy !== 1'b0 || tx !== 1'b1 || puf_enable !== 1'b0) viol++;
        end
        $display("done_idle: %0d active cycles", viol);
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL done_idle got %0d active cycles need 0", viol); end
        n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL done_idle_rx got %0d bytes need 0", rx_q.size()); end
    endtask

    task automatic test_reset_midbyte;
        bit ok;
        int k, viol;
        challenge = 8'hE1; response = 8'h1E;
        run = 1'b1;
        wait_pe_high(10, ok);
        done_man = 1'b1;
        k = 0;
        while (tx !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_active got busy=%b need 1", busy); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL midrst_tx got %b need 1", tx); end
        n_cmp++; if (busy !== 1'b0 || puf_enable !== 1'b0 || computer_ack !== 1'b0) begin
            n_err++; $display("FAIL midrst_outs got busy=%b pe=%b ack=%b need 0/0/0", busy, puf_enable, computer_ack);
        end
        n_cmp++; if (sample_count !== 8'd0) begin n_err++; $display("FAIL midrst_count got %0d need 0", sample_count); end
        run = 1'b0; done_man = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL midrst_no_resume got %0d active cycles need 0", viol); end
        rx_q.delete(); rx_stop_q.delete(); exp_q.delete();
        $display("midrst: reset during byte checked");
    endtask

    task automatic test_back_to_back;
        bit ok;
        int k, gap;
        logic [7:0] e, g;
        logic s;
        challenge = 8'h5C; response = 8'hC3;
        auto_mode = 1'b1;
        run = 1'b1;
        for (int f = 0; f < 256; f++) begin
            k = 0;
            while (puf_enable !== 1'b1 && k < 20) begin @(negedge clk); k++; end
            n_cmp++; if (puf_enable !== 1'b1) begin n_err++; $display("FAIL b2b_arm frame %0d got pe=%b need 1", f, puf_enable); end
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h5C);
            exp_q.push_back(8'hC3);
            if (f == 255) run = 1'b0;
            k = 0;
            while (busy !== 1'b0 && k < 400) begin @(negedge clk); k++; end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_end frame %0d got busy=%b need 0", f, busy); end
            n_cmp++; if (rx_q.size() < 3) begin n_err++; $display("FAIL b2b_rx frame %0d got %0d bytes need 3", f, rx_q.size()); end
            while (rx_q.size() > 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front(); g = rx_q.pop_front(); s = rx_stop_q.pop_front();
                n_cmp++; if (g !== e || s !== 1'b1) begin n_err++; $display("FAIL b2b_byte frame %0d got %02h/stop %b need %02h/stop 1", f, g, s, e); end
            end
            exp_q.delete();
            n_cmp++; if (sample_count !== 8'(f + 1)) begin n_err++; $display("FAIL b2b_count frame %0d got %0d need %0d", f, sample_count, 8'(f + 1)); end
            gap = 0;
            while (busy === 1'b0 && gap < 20) begin gap++; @(negedge clk); end
            if (f < 255) begin
                n_cmp++; if (gap != 1) begin n_err++; $display("FAIL b2b_gap frame %0d got %0d idle cycles need 1", f, gap); end
            end
            $display("b2b: frame %0d count %0d idle gap %0d", f, sample_count, gap);
        end
        n_cmp++; if (sample_count !== 8'd0) begin n_err++; $display("FAIL b2b_wrap got %0d need 0", sample_count); end
        auto_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_run_drop();
        test_done_idle();
        test_reset_midbyte();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/puf_response_uart.md
PUF_RESPONSE_UART -- requirements
Module: puf_response_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, meaning clk cycles per UART bit (12 MHz / 9600 baud).
REQ-002 SHALL have parameter ACK_CYCLES, default 4, meaning minimum computer_ack pulse width in clk cycles.
REQ-003 SHALL have parameter TIMEOUT, default 65535, meaning maximum clk cycles waited for done.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  level request; high starts one evaluation per loop.
REQ-007 challenge  input  8  challenge currently applied to the PUF.
REQ-008 response  input  8  PUF response bits.
REQ-009 done  input  1  PUF evaluation complete.
REQ-010 puf_enable  output  1  arms all PUF enables.
REQ-011 computer_ack  output  1  PUF reset/acknowledge strobe.
REQ-012 tx  output  1  UART serial line, idle high.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 sample_count  output  8  count of completed frames, wraps 255->0.

Function
REQ-015 SHALL implement states IDLE, ARM, SEND_HDR, SEND_CHAL, SEND_RESP, ACK, WAIT_LOW.
REQ-016 IDLE: when run=1, next cycle enters ARM with puf_enable=1; timeout counter cleared.
REQ-017 ARM: done and challenge/response are first passed through two-flop synchronisers; sampled done=1 captures challenge and response into holding registers, drops puf_enable, enters SEND_HDR.
REQ-018 ARM: if timeout counter reaches TIMEOUT before done, drop puf_enable, load response register with 0xEE, challenge register with current challenge, header with 0x5A, enter SEND_HDR.
REQ-019 Normal header byte SHALL be 0xA5; error header 0x5A.
REQ-020 Each SEND_* state transmits one byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly CLKS_PER_BIT cycles; next state entered on the cycle after stop bit ends; no idle gap between bytes required.
REQ-021 Byte order SHALL be header, challenge, response.
REQ-022 After SEND_RESP, enter ACK: computer_ack=1 for ACK_CYCLES cycles, sample_count increments once on ACK entry.
REQ-023 WAIT_LOW: computer_ack held 1 until synchronised done=0, then computer_ack=0 and return to IDLE; timeout frames skip the wait (done already 0 or ignored after ACK_CYCLES).
REQ-024 run falling mid-frame SHALL NOT abort; frame completes, then IDLE holds.
REQ-025 run held high SHALL cause back-to-back evaluations, one IDLE cycle between.
REQ-026 done rising outside ARM SHALL be ignored.
REQ-027 Holding registers SHALL remain stable from capture until return to IDLE.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, tx=1, puf_enable=0, computer_ack=0, busy=0, sample_count=0, all counters and registers 0.
REQ-029 Reset mid-frame SHALL truncate the byte with tx=1 immediately; no partial frame resumes after release.

Structure
REQ-030 State encodings, header constants (0xA5, 0x5A, 0xEE) SHALL live in shared package puf_pkg.
REQ-031 Bit-serialiser SHALL be sub-module uart_tx_byte (start/data in, busy/tx out, CLKS_PER_BIT parameter).

Verification (CLKS_PER_BIT=4, ACK_CYCLES=4, TIMEOUT=100)
REQ-032 Reset: rst_n=0 mid-byte -> tx=1, all outputs 0 same cycle, sample_count=0.
REQ-033 Normal: run=1, challenge=0x3C, done after 20 cycles with response=0x96 -> tx bytes A5,3C,96 each 40 cycles, then computer_ack high >=4 cycles until done=0, sample_count=1.
REQ-034 Timeout: run=1, done never rises -> puf_enable drops at cycle 100, bytes 5A,chal,EE, computer_ack 4 cycles.
REQ-035 run dropped during SEND_CHAL -> full 3-byte frame still sent, then IDLE, puf_enable stays 0.
REQ-036 run held high 256 frames -> sample_count wraps to 0, one IDLE cycle between frames.
REQ-037 done pulse while IDLE -> no tx activity, busy=0.
